pb_port_hub: RTL and testbench
==============================

// Module: pb_port_hub
// PURPOSE
//  Parametrised PicoBlaze I/O port hub: decodes port_id/strobes into NUM_IN input
//  ports, NUM_OUT output ports, a status port and an interrupt controller.
//  Sits between the CPU and peripherals (UART, switches, LEDs, audio FIFOs).
//  Adds registered output strobes, edge-qualified pop acks and masked,
//  latched interrupts with an interrupt_ack handshake.
// PARAMETERS
//  NUM_IN        4      input ports, 1..8, at addresses IN_BASE+p
//  NUM_OUT       4      output ports, 1..8, at addresses OUT_BASE+p
//  IN_BASE       8'h00  address of input port 0
//  OUT_BASE      8'h10  address of output port 0
//  POP_MASK      4'b0010  bit p=1: read of input p pulses in_ack[p] (FIFO pop)
//  STATUS_ADDR   8'h20  read: {zero-pad, irq_src}
//  IRQ_MASK_ADDR 8'h21  read/write: interrupt mask register
//  IRQ_PEND_ADDR 8'h22  read: pending bits; write: write-1-to-clear
// PORTS
//  clk            in   1          system clock (100 MHz)
//  reset          in   1          asynchronous, active-high reset
//  port_id        in   8          PicoBlaze port address
//  read_strobe    in   1          PicoBlaze read strobe
//  write_strobe   in   1          PicoBlaze write strobe
//  out_port       in   8          PicoBlaze write data
//  in_port        out  8          registered read data to PicoBlaze
//  in_data        in   NUM_IN*8   peripheral read data, port p = bits [8p+7:8p]
//  in_ack         out  NUM_IN     one-cycle pop pulse per input port
//  out_data       out  8          registered write data to peripherals
//  out_we         out  NUM_OUT    one-cycle write-enable pulse per output port
//  irq_src        in   NUM_IN     level interrupt sources (e.g. data_present)
//  interrupt      out  1          interrupt request to PicoBlaze
//  interrupt_ack  in   1          PicoBlaze interrupt acknowledge
// BEHAVIOUR
//  Reset: in_port=0, in_ack=0, out_data=0, out_we=0, interrupt=0, mask=0,
//   pending=0, irq_src history=0, read/write strobe history=0, FSM=IDLE.
//  Read mux: every clk, in_port <= data selected by port_id (1-cycle latency);
//   unmapped address -> 8'h00. Decode priority: STATUS > IRQ_MASK > IRQ_PEND > IN.
//  Pop: in_ack[p] is high for exactly one cycle, the cycle after the first cycle
//   of read_strobe with port_id==IN_BASE+p and POP_MASK[p]=1. A strobe held N
//   cycles yields one pulse. A read with POP_MASK[p]=0 yields no pulse.
//  Write: on a write_strobe rising edge with port_id==OUT_BASE+p, next cycle
//   out_data<=out_port and out_we[p]=1 for one cycle. out_data holds between writes.
//   Writes to IRQ_MASK_ADDR/IRQ_PEND_ADDR update internal registers only.
//  Pending: pending[p] is set on an irq_src[p] rising edge (registered compare).
//   A W1C write clears the written bits. Set and clear in the same cycle -> set wins.
//  IRQ FSM:
//   IDLE: if |(pending & mask) -> ASSERT.
//   ASSERT: interrupt=1; interrupt_ack=1 -> HOLDOFF.
//   HOLDOFF: interrupt=0 for 1 cycle -> IDLE.
//   The FSM re-asserts from IDLE if any masked pending bit is still set.
//   Clearing the mask or pending bits while in ASSERT -> IDLE next cycle, interrupt=0.
//  Reset asserted mid-operation: all state returns to reset values immediately.
//   No out_we or in_ack pulse is emitted on reset release.
//  Widths: unused upper status/pending/mask bits (>= NUM_IN) read as 0.
//   Writes to those bits are ignored.
// TESTING
//  1. Reset, then read every in-range address -> in_port=0 for regs; in_port=in_data byte for IN ports.
//  2. in_data[15:8]=8'hA5, read port 8'h01 (strobe held 2 cycles) -> in_port=8'hA5, in_ack=4'b0010 for exactly 1 cycle.
//  3. Write 8'h3C to 8'h12 -> next cycle out_data=8'h3C, out_we=4'b0100 for 1 cycle, other bits 0.
//  4. mask=4'b0001, irq_src[0] 0->1 -> interrupt=1; interrupt_ack -> 1 low cycle, then re-asserts; W1C 8'h01 to 8'h22 -> stays 0.
//  5. W1C of bit0 in the same cycle as an irq_src[0] rising edge -> pending[0] stays 1.
//  6. Assert reset while interrupt=1 and during a write -> interrupt=0, out_we=0, mask=0, pending=0.

Source files
------------

// File: rtl/pb_port_hub.sv
// pb_port_hub: PicoBlaze port decoder with registered strobes, pop acks and a masked interrupt controller
module pb_port_hub #(
  parameter int         NUM_IN        = 4,
  parameter int         NUM_OUT       = 4,
  parameter logic [7:0] IN_BASE       = 8'h00,
  parameter logic [7:0] OUT_BASE      = 8'h10,
  parameter logic [7:0] POP_MASK      = 8'b0000_0010,
  parameter logic [7:0] STATUS_ADDR   = 8'h20,
  parameter logic [7:0] IRQ_MASK_ADDR = 8'h21,
  parameter logic [7:0] IRQ_PEND_ADDR = 8'h22
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            port_id,
  input  logic                  read_strobe,
  input  logic                  write_strobe,
  input  logic [7:0]            out_port,
  output logic [7:0]            in_port,
  input  logic [NUM_IN*8-1:0]   in_data,
  output logic [NUM_IN-1:0]     in_ack,
  output logic [7:0]            out_data,
  output logic [NUM_OUT-1:0]    out_we,
  input  logic [NUM_IN-1:0]     irq_src,
  output logic                  interrupt,
  input  logic                  interrupt_ack
);
  typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} st_t;
  st_t st_q, st_d;
  logic [7:0] in_port_q, in_port_d, out_data_q, out_data_d;
  logic [NUM_IN-1:0] ack_q, ack_d, mask_q, mask_d, pend_q, pend_d, src_q, clr;
  logic [NUM_OUT-1:0] we_q, we_d;
  logic rs_q, ws_q, is_stat, is_mask, is_pend, wr_e, irq_any;
  assign is_stat = port_id == STATUS_ADDR;
  assign is_mask = port_id == IRQ_MASK_ADDR;
  assign is_pend = port_id == IRQ_PEND_ADDR;
  assign wr_e    = write_strobe & ~ws_q;
  assign irq_any = |(pend_q & mask_q);
  // read mux with register addresses taking priority over input ports, plus first-cycle pop decode
  always_comb begin
    in_port_d = 8'h00;
    ack_d = '0;
    for (int p = 0; p < NUM_IN; p++) begin
      if (port_id == IN_BASE + 8'(p)) in_port_d = in_data[8*p +: 8];
      ack_d[p] = read_strobe & ~rs_q & POP_MASK[p] & ~(is_stat | is_mask | is_pend) & (port_id == IN_BASE + 8'(p));
    end
    in_port_d = is_stat ? 8'(irq_src) : is_mask ? 8'(mask_q) : is_pend ? 8'(pend_q) : in_port_d;
  end
  // write-edge decode; set beats clear on pending so a coincident edge is never lost
  always_comb begin
    we_d = '0;
    for (int p = 0; p < NUM_OUT; p++) we_d[p] = wr_e & (port_id == OUT_BASE + 8'(p));
    out_data_d = |we_d ? out_port : out_data_q;
    mask_d = wr_e & is_mask ? out_port[NUM_IN-1:0] : mask_q;
    clr = wr_e & is_pend ? out_port[NUM_IN-1:0] : '0;
    pend_d = (pend_q & ~clr) | (irq_src & ~src_q);
  end
  // interrupt FSM; request drops at once if the masked pending set empties
  always_comb begin
    st_d = st_q;
    interrupt = 1'b0;
    case (st_q)
      IDLE: st_d = irq_any ? ASSERT : IDLE;
      ASSERT: begin
        interrupt = irq_any;
        st_d = interrupt_ack ? HOLDOFF : irq_any ? ASSERT : IDLE;
      end
      default: st_d = IDLE;
    endcase
  end
  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= IDLE;
      in_port_q <= '0;
      out_data_q <= '0;
      ack_q <= '0;
      we_q <= '0;
      mask_q <= '0;
      pend_q <= '0;
      src_q <= '0;
      rs_q <= 1'b0;
      ws_q <= 1'b0;
    end else begin
      st_q <= st_d;
      in_port_q <= in_port_d;
      out_data_q <= out_data_d;
      ack_q <= ack_d;
      we_q <= we_d;
      mask_q <= mask_d;
      pend_q <= pend_d;
      src_q <= irq_src;
      rs_q <= read_strobe;
      ws_q <= write_strobe;
    end
  end
  assign in_port = in_port_q;
  assign in_ack = ack_q;
  assign out_data = out_data_q;
  assign out_we = we_q;
endmodule

// File: tb/tb_pb_port_hub.sv
// tb_pb_port_hub: scoreboard bench for the PicoBlaze port hub
module tb_pb_port_hub;
  logic clk = 0, reset = 1, read_strobe = 0, write_strobe = 0, interrupt_ack = 0, interrupt;
  logic [7:0] port_id = 0, out_port = 0, in_port, out_data, od_m = 0;
  logic [31:0] in_data = 0;
  logic [3:0] in_ack, out_we, irq_src = 0;
  int total = 0, bad = 0;
  string tq[$];
  logic [15:0] vq[$];
  always #5 clk = ~clk;
  pb_port_hub dut (
    .clk(clk), .reset(reset), .port_id(port_id), .read_strobe(read_strobe),
    .write_strobe(write_strobe), .out_port(out_port), .in_port(in_port),
    .in_data(in_data), .in_ack(in_ack), .out_data(out_data), .out_we(out_we),
    .irq_src(irq_src), .interrupt(interrupt), .interrupt_ack(interrupt_ack)
  );
  task chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task push(input string t, input logic [15:0] v);
    tq.push_back(t);
    vq.push_back(v);
  endtask
  task pop(input logic [15:0] got);
    string t;
    logic [15:0] v;
    t = tq.pop_front();
    v = vq.pop_front();
    chk(t, got, v);
  endtask
  task rd(input logic [7:0] a, input int n, input logic [7:0] d, input logic [3:0] ack);
    port_id = a;
    read_strobe = 1;
    for (int i = 0; i < n; i++) begin
      push($sformatf("rd%02h_%0d", a, i), {d, 4'h0, i == 0 ? ack : 4'h0});
      @(negedge clk);
      pop({in_port, 4'h0, in_ack});
    end
    read_strobe = 0;
    push($sformatf("rd%02h_end", a), {d, 8'h00});
    @(negedge clk);
    pop({in_port, 4'h0, in_ack});
  endtask
  task wr(input logic [7:0] a, input logic [7:0] d);
    logic [3:0] we;
    we = 4'h0;
    if (a >= 8'h10 && a < 8'h14) begin
      od_m = d;
      we = 4'b1 << (a - 8'h10);
    end
    port_id = a;
    out_port = d;
    write_strobe = 1;
    push($sformatf("wr%02h", a), {od_m, 4'h0, we});
    @(negedge clk);
    pop({out_data, 4'h0, out_we});
    write_strobe = 0;
    push($sformatf("wr%02h_end", a), {od_m, 8'h00});
    @(negedge clk);
    pop({out_data, 4'h0, out_we});
  endtask
  task wait_int(input logic v, input string tag);
    int k;
    k = 0;
    while (interrupt !== v && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {15'h0, interrupt}, {15'h0, v});
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_outs", {in_port, in_ack, out_we}, 16'h0);
    chk("rst_od_int", {out_data, 7'h0, interrupt}, 16'h0);
    reset = 0;
    in_data = 32'h44332211;
    rd(8'h00, 1, 8'h11, 4'h0);
    rd(8'h01, 1, 8'h22, 4'h2);
    rd(8'h02, 1, 8'h33, 4'h0);
    rd(8'h03, 1, 8'h44, 4'h0);
    rd(8'h20, 1, 8'h00, 4'h0);
    rd(8'h21, 1, 8'h00, 4'h0);
    rd(8'h22, 1, 8'h00, 4'h0);
    rd(8'h05, 1, 8'h00, 4'h0);
    rd(8'h10, 1, 8'h00, 4'h0);
    in_data[15:8] = 8'hA5;
    rd(8'h01, 2, 8'hA5, 4'h2);
    rd(8'h00, 3, 8'h11, 4'h0);
    wr(8'h12, 8'h3C);
    wr(8'h13, 8'h5A);
    wr(8'h30, 8'h77);
    wr(8'h21, 8'hFF);
    rd(8'h21, 1, 8'h0F, 4'h0);
    wr(8'h21, 8'h01);
    rd(8'h21, 1, 8'h01, 4'h0);
    irq_src[1] = 1;
    repeat (3) @(negedge clk);
    chk("masked_int", {15'h0, interrupt}, 16'h0);
    rd(8'h22, 1, 8'h02, 4'h0);
    wr(8'h22, 8'h02);
    rd(8'h22, 1, 8'h00, 4'h0);
    irq_src[0] = 1;
    wait_int(1, "int_set");
    interrupt_ack = 1;
    @(negedge clk);
    interrupt_ack = 0;
    chk("holdoff", {15'h0, interrupt}, 16'h0);
    wait_int(1, "reassert");
    rd(8'h20, 1, 8'h03, 4'h0);
    wr(8'h22, 8'h01);
    wait_int(0, "w1c_drop");
    repeat (3) @(negedge clk);
    chk("stay_low", {15'h0, interrupt}, 16'h0);
    rd(8'h22, 1, 8'h00, 4'h0);
    irq_src[0] = 0;
    @(negedge clk);
    port_id = 8'h22;
    out_port = 8'h01;
    write_strobe = 1;
    irq_src[0] = 1;
    @(negedge clk);
    write_strobe = 0;
    @(negedge clk);
    rd(8'h22, 1, 8'h01, 4'h0);
    wait_int(1, "int_pre_rst");
    port_id = 8'h11;
    out_port = 8'h99;
    write_strobe = 1;
    #2 reset = 1;
    #1 chk("rst_async_int", {15'h0, interrupt}, 16'h0);
    @(negedge clk);
    chk("rst_mid_outs", {out_data, in_ack, out_we}, 16'h0);
    write_strobe = 0;
    irq_src = 0;
    od_m = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rel_outs", {7'h0, interrupt, in_ack, out_we}, 16'h0);
    rd(8'h21, 1, 8'h00, 4'h0);
    rd(8'h22, 1, 8'h00, 4'h0);
    chk("rel_od", {out_data, 7'h0, interrupt}, 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
